// File: rtl/sub_result_display_if.sv
// ---------------------------------------------------------------------------
// sub_result_display_if
//   Valid/ready handshake carrying one subtractor result into the display
//   driver.
//   valid_i  : upstream presents a new difference
//   ready_o  : display driver can accept a value this cycle
//   result_i : 4-bit subtractor result
//   sign_i   : 1 = non-negative, 0 = negative (result_i is two's complement)
// ---------------------------------------------------------------------------
interface sub_result_display_if;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] result_i;
  logic       sign_i;

  modport master (
    output valid_i,
    output result_i,
    output sign_i,
    input  ready_o
  );

  modport slave (
    input  valid_i,
    input  result_i,
    input  sign_i,
    output ready_o
  );
endinterface

// File: rtl/sub_result_display.sv
// ---------------------------------------------------------------------------
// sub_result_display
//   Three-digit multiplexed common-anode 7-segment driver for the 4-bit
//   subtractor output. A value is captured on the valid/ready handshake,
//   converted to signed decimal magnitude in one cycle, and then scanned as
//   sign / tens / units digits. The value is held until a new one arrives.
//
//   Parameters
//     REFRESH_DIV : clock cycles each digit stays enabled (>= 2)
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     up     : handshake interface (slave side)
//     seg_o  : segments {g,f,e,d,c,b,a}, active low, registered
//     an_o   : digit enables {sign,tens,units}, active low, registered
// ---------------------------------------------------------------------------
module sub_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sub_result_display_if.slave  up,
  output logic [6:0]           seg_o,
  output logic [2:0]           an_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            ready_q;
  logic            accept;

  logic [3:0]      result_p0;
  logic            sign_p0;

  logic            tens_p1;
  logic [3:0]      units_p1;
  logic            neg_p1;

  logic [3:0]      mag_c;
  logic            tens_c;
  logic [3:0]      units_c;
  logic            neg_c;

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;

  // Magnitude of the signed 5-bit value {~sign, result}. The negative case
  // wraps modulo 16, so "negative zero" (sign 0, result 0) yields 0.
  function automatic logic [3:0] mag_of(input logic [3:0] r, input logic s);
    logic signed [4:0] d;
    logic signed [4:0] a;
    d = s ? signed'({1'b0, r}) : signed'({1'b1, r});
    a = (d < 0) ? -d : d;
    return a[3:0];
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign up.ready_o = ready_q;
  assign accept     = up.valid_i && ready_q;

  // ---- control FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != CONVERT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONVERT;
      CONVERT: state_nxt = SHOW;
      SHOW:    if (accept) state_nxt = CONVERT;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: capture on handshake ----
  always_ff @(posedge clk) begin
    if (accept) begin
      result_p0 <= up.result_i;
      sign_p0   <= up.sign_i;
    end
  end

  // ---- stage p1: decimal conversion, held until the next CONVERT ----
  always_comb begin
    mag_c   = mag_of(result_p0, sign_p0);
    tens_c  = (mag_c >= 4'd10);
    units_c = tens_c ? (mag_c - 4'd10) : mag_c;
    neg_c   = !sign_p0 && (mag_c != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_p1  <= 1'b0;
      units_p1 <= 4'd0;
      neg_p1   <= 1'b0;
    end else if (state == CONVERT) begin
      tens_p1  <= tens_c;
      units_p1 <= units_c;
      neg_p1   <= neg_c;
    end
  end

  // ---- free-running scan: never restarted by captures ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---- stage p2: registered segment/anode drive ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_BLANK;
      an_o  <= 3'b111;
    end else if (state == IDLE) begin
      seg_o <= SEG_BLANK;
      an_o  <= 3'b111;
    end else begin
      case (idx)
        2'd0: begin
          an_o  <= 3'b110;
          seg_o <= seg_digit(units_p1);
        end
        2'd1: begin
          an_o  <= 3'b101;
          seg_o <= tens_p1 ? SEG_ONE : SEG_BLANK;
        end
        2'd2: begin
          an_o  <= 3'b011;
          seg_o <= neg_p1 ? SEG_MINUS : SEG_BLANK;
        end
        default: begin
          an_o  <= 3'b111;
          seg_o <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule
